// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
//   N_REQ  : number of requesters
//   IDX_W  : width of a requester index
//   state_t: arbiter FSM state
//   onehot : index -> one-hot grant vector
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One-hot vector with only bit idx set.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : arb_pkg

// File: rtl/rr_arbiter_4_if.sv
// Handshake bundle between the clients and the arbiter.
//   req     : level request vector, bit i = requester i
//   done    : one-cycle release pulse from the current owner
//   gnt     : one-hot grant
//   gnt_idx : binary index of the owner (0 when no grant)
//   gnt_v   : grant valid
//   timeout : one-cycle pulse when the owner was forced off
// Modports: master = client side, slave = arbiter side.
interface rr_arbiter_4_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_v;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_v,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_v,
        output timeout
    );

endinterface : rr_arbiter_4_if

// File: rtl/rr_arbiter_4_pick.sv
// Rotating-priority encoder: picks the first set request bit scanning
// ptr, ptr+1, ... modulo N_REQ.
//   req : request vector
//   ptr : index with highest priority
//   sel : selected requester index (0 when none)
//   any : at least one request is set
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] sel,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    // Rotate so that requester ptr lands on bit 0; index arithmetic wraps mod 4.
    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rot[i] = req[IDX_W'(i) + ptr];
        end
    end

    // Fixed-priority encode, lowest rotated bit wins (scan high to low).
    always_comb begin
        off = '0;
        any = 1'b0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

    // Un-rotate back to an absolute requester index.
    assign sel = off + ptr;

endmodule : rr_pick

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold, release handshake,
// fairness pointer and forced release after MAX_HOLD cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of rr_arbiter_4_if (req/done in, grant out)
// MAX_HOLD = 0 disables the timeout; CNT_W must satisfy 2**CNT_W > MAX_HOLD.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNT_W    = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter_4_if.slave    bus
);

    state_t           state_q,    state_d;
    logic [IDX_W-1:0] ptr_q,      ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] gnt_q,      gnt_d;
    logic [IDX_W-1:0] gnt_idx_q,  gnt_idx_d;
    logic             gnt_v_q,    gnt_v_d;
    logic             timeout_q,  timeout_d;

    logic [IDX_W-1:0] pick_sel;
    logic             pick_any;

    logic             rel_done;
    logic             rel_drop;
    logic             rel_to;

    rr_pick u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .sel (pick_sel),
        .any (pick_any)
    );

    // Release causes while busy; done and a dropped request both outrank the timeout.
    always_comb begin
        rel_done = bus.done;
        rel_drop = ~bus.req[gnt_idx_q];
        rel_to   = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD))
                   && !rel_done && !rel_drop;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_v_d    = gnt_v_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d      = onehot(pick_sel);
                    gnt_idx_d  = pick_sel;
                    gnt_v_d    = 1'b1;
                    hold_cnt_d = CNT_W'(1);
                    state_d    = BUSY;
                end else begin
                    gnt_d      = '0;
                    gnt_idx_d  = '0;
                    gnt_v_d    = 1'b0;
                end
            end
            BUSY: begin
                if (rel_done || rel_drop || rel_to) begin
                    gnt_d      = '0;
                    gnt_idx_d  = '0;
                    gnt_v_d    = 1'b0;
                    hold_cnt_d = '0;
                    // Owner 3 wraps the pointer back to 0 via 2-bit arithmetic.
                    ptr_d      = gnt_idx_q + IDX_W'(1);
                    timeout_d  = rel_to;
                    state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_v_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_v_q    <= gnt_v_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_v   = gnt_v_q;
    assign bus.timeout = timeout_q;

endmodule : rr_arbiter_4
